tx_control: RTL and testbench
=============================

// Module: tx_control
// PURPOSE
//  UART transmitter: serialises one DATA_WIDTH-bit word per frame onto s_data_out, LSB first.
//  Frame: start(0), data, optional parity, one stop(1). Bit timing comes from the shared bclk
//  oversampling tick, SAMPLING ticks per bit. Counterpart of the UART receive path; the
//  parity encoding and frame format are identical, so TX->RX loopback is lossless.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame
//  SAMPLING    16  bclk ticks per serial bit
// PORTS
//  clk           in   1           system clock; all logic on posedge clk
//  reset         in   1           asynchronous, active-high
//  bclk          in   1           baud oversample tick, single-clk-wide enable pulse
//  p_data_in     in   DATA_WIDTH  word to send
//  data_valid    in   1           request; word accepted when data_valid & tx_ready
//  tx_ready      out  1           high only in IDLE; combinational from state
//  parity        in   2           00 none, 01 odd, 10 even, 11 none
//  s_data_out    out  1           serial line, registered, idles high
//  tx_busy       out  1           high from accept cycle+1 until frame end
//  tx_done       out  1           one-clk pulse on last stop-bit tick
// BEHAVIOUR
//  Reset (async): state IDLE, s_data_out=1, tx_busy=0, tx_done=0, counters=0, shift reg=0.
//  States: IDLE -> START -> DATA -> (PARITY if parity is 01/10) -> STOP -> IDLE.
//  Accept: in IDLE, data_valid=1 on a clk edge latches p_data_in and parity into internal
//   registers, clears tick and bit counters, enters START. s_data_out=0 from the next clk.
//   Latched config is used for the whole frame; input changes mid-frame are ignored.
//  data_valid while not IDLE: ignored; no queueing; requester must hold until tx_ready.
//  Tick counter: 4+ bits, counts bclk ticks after the accept cycle; a bclk in the accept
//   cycle itself is not counted. Each bit ends on the tick where counter == SAMPLING-1;
//   the counter then wraps to 0 and the next bit is driven on the following clk.
//  DATA: bit i = latched word[i], i = 0..DATA_WIDTH-1; bit counter increments at bit end;
//   leaves DATA after bit DATA_WIDTH-1.
//  PARITY: odd -> ~^word; even -> ^word (total ones incl. parity odd/even respectively).
//  STOP: drives 1; at its final tick, tx_done=1 for that clk, state -> IDLE, tx_busy -> 0.
//  tx_ready is high again the clk after tx_done; a held data_valid is accepted there,
//   giving back-to-back frames with no extra idle bit.
//  Frame length: (DATA_WIDTH+2+P)*SAMPLING bclk ticks, P = 1 if parity is 01/10, else 0.
//  No bclk: FSM stalls in the current bit, line holds its level.
//  s_data_out never glitches: it changes only at bit boundaries or on reset.
//  Reset mid-frame: line forced to 1 at once, frame dropped, no tx_done.
// TESTING
//  (bclk every 4 clk, SAMPLING=16 -> 64 clk/bit for all cases)
//  T1 0xA5, parity=00 -> line 0,1,0,1,0,0,1,0,1,1 at 64 clk/bit; tx_done once after 640 clk.
//  T2 0xA5 even -> parity bit 0; odd -> parity bit 1; frame = 11 bits; 0x01 even -> 1, odd -> 0.
//  T3 data_valid held with 0x3C then 0xC3 -> second start bit immediately after first stop;
//     data_valid pulsed while busy -> ignored, line unchanged.
//  T4 reset asserted during DATA bit 3 -> s_data_out=1 same cycle, tx_ready=1, no tx_done;
//     next request sends a full clean frame.
//  T5 p_data_in/parity changed mid-frame -> frame carries the values latched at accept.
//  T6 loopback to receiver, 256 random words x parity 00/01/10 -> all received,
//     no parity_error/stop_error.

Source files
------------

// File: rtl/tx_control.sv
// tx_control: UART transmitter.
// Sends one DATA_WIDTH-bit word per frame, LSB first. The frame is a start bit (0),
// the data bits, an optional parity bit and one stop bit (1). Bit timing comes from
// the shared bclk oversampling enable, SAMPLING ticks per serial bit. The frame
// format and parity encoding match the UART receive path.
module tx_control #(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLING   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    input  logic                  data_valid,
    output logic                  tx_ready,
    input  logic [1:0]            parity,
    output logic                  s_data_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    // The tick counter is at least 4 bits wide even for small SAMPLING values.
    localparam int TICK_W = ($clog2(SAMPLING) > 4) ? $clog2(SAMPLING) : 4;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    // Parity mode encoding shared with the receiver.
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // A parity bit is only sent for the odd and even modes; 00 and 11 mean none.
    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_ODD:  en = 1'b1;
            PAR_EVEN: en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // Parity bit that makes the total number of ones (data plus parity)
    // odd for the odd mode and even for the even mode.
    function automatic logic parity_value(input logic [DATA_WIDTH-1:0] word,
                                          input logic [1:0]            mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~(^word);
            PAR_EVEN: p = ^word;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    state_t                  state_r;
    logic [TICK_W-1:0]       tick_r;
    logic [BIT_W-1:0]        bit_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    par_en_r;
    logic                    par_bit_r;

    logic                    bit_end_s;
    logic [DATA_WIDTH-1:0]   shift_next_s;

    // The ready handshake is a pure decode of the state so a requester sees it
    // in the same cycle the transmitter returns to idle.
    assign tx_ready = (state_r == IDLE);

    // Bit boundary: the tick that completes the SAMPLING ticks of the current bit,
    // plus the shifted word whose LSB becomes the next data bit.
    always_comb begin
        bit_end_s    = 1'b0;
        shift_next_s = shift_r >> 1;
        if (bclk && (tick_r == TICK_LAST)) begin
            bit_end_s = 1'b1;
        end else begin
            bit_end_s = 1'b0;
        end
    end

    // Frame sequencer: accepts a word in IDLE, then walks start/data/parity/stop,
    // updating the registered line only at bit boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            tick_r     <= {TICK_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            s_data_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Bit-time counting runs in every active state; a bclk seen in the
            // accept cycle is deliberately not counted (the IDLE branch below
            // clears the counter instead).
            if (state_r != IDLE) begin
                if (bit_end_s) begin
                    tick_r <= {TICK_W{1'b0}};
                end else if (bclk) begin
                    tick_r <= tick_r + TICK_W'(1);
                end else begin
                    tick_r <= tick_r;
                end
            end else begin
                tick_r <= tick_r;
            end

            case (state_r)
                IDLE: begin
                    s_data_out <= 1'b1;
                    tx_busy    <= 1'b0;
                    if (data_valid) begin
                        // Word and parity mode are frozen here for the whole frame.
                        shift_r    <= p_data_in;
                        par_en_r   <= parity_enabled(parity);
                        par_bit_r  <= parity_value(p_data_in, parity);
                        tick_r     <= {TICK_W{1'b0}};
                        bit_r      <= {BIT_W{1'b0}};
                        s_data_out <= 1'b0;
                        tx_busy    <= 1'b1;
                        state_r    <= START;
                    end else begin
                        state_r    <= IDLE;
                    end
                end

                START: begin
                    if (bit_end_s) begin
                        s_data_out <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        state_r    <= START;
                    end
                end

                DATA: begin
                    if (bit_end_s) begin
                        if (bit_r == BIT_LAST) begin
                            if (par_en_r) begin
                                s_data_out <= par_bit_r;
                                state_r    <= PARITY;
                            end else begin
                                s_data_out <= 1'b1;
                                state_r    <= STOP;
                            end
                        end else begin
                            bit_r      <= bit_r + BIT_W'(1);
                            shift_r    <= shift_next_s;
                            s_data_out <= shift_next_s[0];
                            state_r    <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end

                PARITY: begin
                    if (bit_end_s) begin
                        s_data_out <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        state_r    <= PARITY;
                    end
                end

                STOP: begin
                    if (bit_end_s) begin
                        // Ready rises next cycle, so a held request starts the
                        // following frame without an extra idle bit.
                        s_data_out <= 1'b1;
                        tx_done    <= 1'b1;
                        tx_busy    <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= STOP;
                    end
                end

                default: begin
                    s_data_out <= 1'b1;
                    tx_busy    <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: randomized self-checking bench for tx_control.
// A frame-level reference model expands each accepted word into its list of line
// levels and tracks elapsed bclk ticks; the expected line is simply the bit whose
// SAMPLING-tick window the tick count falls into.
module tb_tx_control;

    localparam int DW = 8;
    localparam int S  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          bclk;
    logic [DW-1:0] p_data_in;
    logic          data_valid;
    logic [1:0]    parity;
    logic          tx_ready;
    logic          s_data_out;
    logic          tx_busy;
    logic          tx_done;

    tx_control #(.DATA_WIDTH(DW), .SAMPLING(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .bclk       (bclk),
        .p_data_in  (p_data_in),
        .data_valid (data_valid),
        .tx_ready   (tx_ready),
        .parity     (parity),
        .s_data_out (s_data_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_ticks  = 0;
    int m_nbits  = 0;
    bit m_bits [0:15];
    bit cap    [0:15];      // DUT line captured mid-bit, per bit index
    int cyc          = 0;
    int stall_left   = 0;
    bit rnd_stall    = 1'b0;
    int frames_exp   = 0;
    int frames_seen  = 0;
    int last_done    = -100;
    int last_accept  = -100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Build the list of line levels for one frame from the word and parity mode.
    task automatic model_accept(input logic [DW-1:0] w, input logic [1:0] mode);
        int ones;
        ones = $countones(w);
        m_bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) m_bits[1 + i] = w[i];
        m_nbits = 1 + DW;
        if (mode == 2'b01) begin
            m_bits[m_nbits] = ((ones % 2) == 0);
            m_nbits++;
        end else if (mode == 2'b10) begin
            m_bits[m_nbits] = ((ones % 2) == 1);
            m_nbits++;
        end
        m_bits[m_nbits] = 1'b1;
        m_nbits++;
        m_active = 1'b1;
        m_ticks  = 0;
        frames_exp++;
        last_accept = cyc;
        for (int i = 0; i < 16; i++) cap[i] = 1'b1;
    endtask

    // One clock: drive bclk, advance the model across the edge, check at negedge.
    task automatic step();
        bclk = !rnd_stall && ((cyc % 4) == 3);
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (!m_active && data_valid) begin
            model_accept(p_data_in, parity);
        end else if (m_active && bclk) begin
            m_ticks++;
            if (m_ticks == m_nbits * S) begin
                m_active  = 1'b0;
                m_done    = 1'b1;
                last_done = cyc;
            end
        end
        @(negedge clk);
        check_eq("line",  32'(s_data_out), m_active ? 32'(m_bits[m_ticks / S]) : 32'd1);
        check_eq("ready", 32'(tx_ready), 32'(!m_active));
        check_eq("busy",  32'(tx_busy),  32'(m_active));
        check_eq("done",  32'(tx_done),  32'(m_done));
        if (tx_done) frames_seen++;
        if (m_active && ((m_ticks % S) == S / 2)) cap[m_ticks / S] = s_data_out;
    endtask

    // Send one word with a single-cycle request and run the frame to completion.
    task automatic send_frame(input logic [DW-1:0] w, input logic [1:0] mode);
        p_data_in  = w;
        parity     = mode;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 1200 && m_active; i++) step();
        check_eq("frame_end", 32'(m_active), 32'd0);
    endtask

    initial begin
        logic [9:0] a5_line;
        reset      = 1'b1;
        bclk       = 1'b0;
        data_valid = 1'b0;
        p_data_in  = 8'h00;
        parity     = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_line",  32'(s_data_out), 32'd1);
        check_eq("rst_ready", 32'(tx_ready),   32'd1);
        check_eq("rst_busy",  32'(tx_busy),    32'd0);
        check_eq("rst_done",  32'(tx_done),    32'd0);
        reset = 1'b0;
        repeat (5) step();

        // 0xA5, no parity: start, 1,0,1,0,0,1,0,1, stop
        send_frame(8'hA5, 2'b00);
        a5_line = 10'b1_1010_0101_0;
        for (int i = 0; i < 10; i++) check_eq("t1_bit", 32'(cap[i]), 32'(a5_line[i]));
        check_eq("t1_count", 32'(frames_seen), 32'd1);

        // Parity bit values
        send_frame(8'hA5, 2'b10);
        check_eq("t2_a5_even", 32'(cap[9]), 32'd0);
        check_eq("t2_stop",    32'(cap[10]), 32'd1);
        send_frame(8'hA5, 2'b01);
        check_eq("t2_a5_odd",  32'(cap[9]), 32'd1);
        send_frame(8'h01, 2'b10);
        check_eq("t2_01_even", 32'(cap[9]), 32'd1);
        send_frame(8'h01, 2'b01);
        check_eq("t2_01_odd",  32'(cap[9]), 32'd0);
        repeat (7) step();

        // Back-to-back with a held request; data change mid-frame is ignored
        p_data_in  = 8'h3C;
        parity     = 2'b00;
        data_valid = 1'b1;
        step();
        p_data_in  = 8'hC3;
        parity     = 2'b01;
        for (int i = 0; i < 1500 && frames_exp < 7; i++) step();
        check_eq("t3_gap", 32'(last_accept - last_done), 32'd1);
        data_valid = 1'b0;
        for (int i = 0; i < 1500 && m_active; i++) step();
        check_eq("t3_word2_bit1", 32'(cap[1]), 32'd1);
        check_eq("t3_word2_par",  32'(cap[9]), 32'd1);

        // Reset during data bit 3 (line index 4)
        p_data_in  = 8'hFF;
        parity     = 2'b10;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 1000 && (m_ticks / S) < 4; i++) step();
        repeat (3) step();
        reset = 1'b1;
        #1;
        check_eq("t4_line",  32'(s_data_out), 32'd1);
        check_eq("t4_ready", 32'(tx_ready),   32'd1);
        check_eq("t4_busy",  32'(tx_busy),    32'd0);
        m_active = 1'b0;
        frames_exp--;
        @(posedge clk);
        @(negedge clk);
        check_eq("t4_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        step();
        send_frame(8'h5A, 2'b01);

        // Randomized traffic with random bclk stalls and mid-frame input churn
        for (int i = 0; i < 40000; i++) begin
            if (stall_left > 0) begin
                stall_left--;
                rnd_stall = 1'b1;
            end else begin
                rnd_stall = 1'b0;
                if ($urandom_range(0, 499) == 0) stall_left = $urandom_range(20, 200);
            end
            data_valid = ($urandom_range(0, 7) == 0);
            p_data_in  = 8'($urandom);
            parity     = 2'($urandom);
            step();
        end
        rnd_stall  = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 2000 && m_active; i++) step();
        check_eq("drain", 32'(m_active), 32'd0);
        check_eq("frames", 32'(frames_seen), 32'(frames_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
